// File: rtl/bht_predictor.sv
// Fetch-stage next-PC predictor: a table of 2-bit saturating counters,
// indexed bimodally (PC bits) or gshare-style (PC bits XOR global history),
// picks between the jal target, the branch target and PC+4. Execute trains
// the table and repairs the global history after a mispredict.
//
// Qualifier semantics: there is no back-pressure in this block.
// F_valid_i marks a fetch that really advances this cycle, and only such a
// fetch may shift the speculative history. E_train_valid_i marks a resolved
// conditional branch. E_mispredict_i only has meaning while E_train_valid_i
// is high. Prediction outputs are driven every cycle whether or not F_valid_i
// is set.
module bht_predictor #(
  parameter int          XLEN      = 32,
  parameter int          PC_WIDTH  = 32,
  parameter int          ENTRIES   = 64,
  parameter int          GHR_WIDTH = 6,
  parameter int          MODE      = 0,
  parameter logic [1:0]  CNT_INIT  = 2'b01,
  localparam int         IDX_W     = $clog2(ENTRIES)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [PC_WIDTH-1:0]  F_PC_i,
  input  logic                 F_valid_i,
  input  logic                 F_op_branch_i,
  input  logic                 F_op_jal_i,
  input  logic [XLEN-1:0]      F_branch_jmp_i,
  input  logic [XLEN-1:0]      F_jal_jmp_i,
  output logic                 pred_taken_o,
  output logic [XLEN-1:0]      pred_npc_o,
  output logic [IDX_W-1:0]     pred_idx_o,
  output logic [GHR_WIDTH-1:0] pred_ghr_o,
  input  logic                 E_train_valid_i,
  input  logic [IDX_W-1:0]     E_train_idx_i,
  input  logic [GHR_WIDTH-1:0] E_train_ghr_i,
  input  logic                 E_train_taken_i,
  input  logic                 E_mispredict_i,
  output logic [31:0]          perf_branch_o,
  output logic [31:0]          perf_miss_o
);

  logic [1:0]           cnt_q [ENTRIES];
  logic [GHR_WIDTH-1:0] ghr_q;
  logic [GHR_WIDTH-1:0] ghr_d;
  logic [IDX_W-1:0]     pc_idx;
  logic [IDX_W-1:0]     fetch_idx;
  logic                 cnt_hi;
  logic                 branch_taken;
  logic [XLEN-1:0]      pc_ext;
  logic [XLEN-1:0]      pc_plus4;
  logic [1:0]           train_cur;
  logic [1:0]           train_upd;
  logic                 miss_valid;
  logic [31:0]          perf_branch_q;
  logic [31:0]          perf_miss_q;

  assign pc_idx = F_PC_i[IDX_W+1:2];

  // Gshare folds the (zero-extended) history into the PC index.
  generate
    if (MODE == 1) begin : g_gshare
      assign fetch_idx = pc_idx ^ IDX_W'(ghr_q);
    end else begin : g_bimodal
      assign fetch_idx = pc_idx;
    end
  endgenerate

  // Prediction reads the registered table directly: no bypass from a
  // same-cycle training write, so the pre-update counter is used.
  assign cnt_hi       = cnt_q[fetch_idx][1];
  assign branch_taken = F_op_branch_i & cnt_hi;
  assign pc_ext       = XLEN'(F_PC_i);
  assign pc_plus4     = pc_ext + XLEN'(4);

  // Next-PC selection: jal beats a predicted-taken branch, which beats PC+4.
  always_comb begin
    pred_npc_o = pc_plus4;
    if (F_op_jal_i) begin
      pred_npc_o = F_jal_jmp_i;
    end else if (branch_taken) begin
      pred_npc_o = F_branch_jmp_i;
    end
  end

  assign pred_taken_o  = F_op_jal_i | branch_taken;
  assign pred_idx_o    = fetch_idx;
  assign pred_ghr_o    = ghr_q;
  assign perf_branch_o = perf_branch_q;
  assign perf_miss_o   = perf_miss_q;

  // Saturating increment/decrement of the counter being trained.
  always_comb begin
    train_cur = cnt_q[E_train_idx_i];
    train_upd = train_cur;
    if (E_train_taken_i) begin
      if (train_cur != 2'b11) train_upd = train_cur + 2'b01;
    end else begin
      if (train_cur != 2'b00) train_upd = train_cur - 2'b01;
    end
  end

  assign miss_valid = E_train_valid_i & E_mispredict_i;

  // History next-state: a mispredict repair rebuilds the history from the
  // snapshot carried with the branch and wins over any speculative shift.
  // Truncating {history, bit} to GHR_WIDTH is the left shift, and also
  // covers the single-bit history case.
  always_comb begin
    ghr_d = ghr_q;
    if (miss_valid) begin
      ghr_d = GHR_WIDTH'({E_train_ghr_i, E_train_taken_i});
    end else if (F_valid_i && F_op_branch_i) begin
      ghr_d = GHR_WIDTH'({ghr_q, pred_taken_o});
    end
  end

  // Counter table: reset to CNT_INIT, written only by execute training.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
    end else if (E_train_valid_i) begin
      cnt_q[E_train_idx_i] <= train_upd;
    end
  end

  // Global history register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  // Performance counters, wrapping naturally at 2^32.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      perf_branch_q <= '0;
      perf_miss_q   <= '0;
    end else begin
      if (E_train_valid_i) perf_branch_q <= perf_branch_q + 32'd1;
      if (miss_valid)      perf_miss_q   <= perf_miss_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Bench for bht_predictor: one bimodal and one gshare instance share all
// inputs. A reference model built from counter values 0..3 and plain integer
// history arithmetic predicts every output each cycle.
`timescale 1ns/100ps
module tb_bht_predictor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- shared inputs ----------------
  logic [31:0] f_pc, f_bt, f_jt;
  logic        f_valid, f_br, f_jal;
  logic        e_tv, e_tt, e_tm;
  logic [5:0]  e_tidx, e_tghr;

  // ---------------- outputs per instance ----------------
  logic        taken0, taken1;
  logic [31:0] npc0, npc1, pb0, pb1, pm0, pm1;
  logic [5:0]  idx0, idx1, ghr0, ghr1;

  bht_predictor #(.MODE(0)) dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .F_PC_i(f_pc), .F_valid_i(f_valid),
    .F_op_branch_i(f_br), .F_op_jal_i(f_jal), .F_branch_jmp_i(f_bt),
    .F_jal_jmp_i(f_jt), .pred_taken_o(taken0), .pred_npc_o(npc0),
    .pred_idx_o(idx0), .pred_ghr_o(ghr0), .E_train_valid_i(e_tv),
    .E_train_idx_i(e_tidx), .E_train_ghr_i(e_tghr), .E_train_taken_i(e_tt),
    .E_mispredict_i(e_tm), .perf_branch_o(pb0), .perf_miss_o(pm0)
  );

  bht_predictor #(.MODE(1)) dut1 (
    .clk_i(clk), .rst_n_i(rst_n), .F_PC_i(f_pc), .F_valid_i(f_valid),
    .F_op_branch_i(f_br), .F_op_jal_i(f_jal), .F_branch_jmp_i(f_bt),
    .F_jal_jmp_i(f_jt), .pred_taken_o(taken1), .pred_npc_o(npc1),
    .pred_idx_o(idx1), .pred_ghr_o(ghr1), .E_train_valid_i(e_tv),
    .E_train_idx_i(e_tidx), .E_train_ghr_i(e_tghr), .E_train_taken_i(e_tt),
    .E_mispredict_i(e_tm), .perf_branch_o(pb1), .perf_miss_o(pm1)
  );

  // ---------------- reference model ----------------
  int unsigned cnt_m [64];   // counter values 0..3
  int unsigned ghr_m [2];    // history per instance (mode 0 / mode 1)
  int unsigned pb_m, pm_m;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) cnt_m[i] = 1;
    ghr_m[0] = 0;
    ghr_m[1] = 0;
    pb_m = 0;
    pm_m = 0;
  endtask

  function automatic int unsigned m_idx(input int m);
    int unsigned base;
    base = (f_pc / 4) % 64;
    return (m == 1) ? (base ^ ghr_m[1]) : base;
  endfunction

  function automatic bit m_taken(input int m);
    return f_jal || (f_br && (cnt_m[m_idx(m)] >= 2));
  endfunction

  function automatic logic [31:0] m_npc(input int m);
    longint unsigned nxt;
    if (f_jal) return f_jt;
    if (f_br && (cnt_m[m_idx(m)] >= 2)) return f_bt;
    nxt = (longint'(f_pc) + 4) % 64'h1_0000_0000;
    return nxt[31:0];
  endfunction

  task automatic idle();
    f_pc = 0; f_bt = 0; f_jt = 0; f_valid = 0; f_br = 0; f_jal = 0;
    e_tv = 0; e_tt = 0; e_tm = 0; e_tidx = 0; e_tghr = 0;
  endtask

  // One clock: compare every output of both instances to the model, take
  // the edge, then advance the model by the same inputs.
  task automatic cycle();
    bit tk [2];
    #1;
    for (int m = 0; m < 2; m++) tk[m] = m_taken(m);
    chk("taken0", {31'd0, taken0}, {31'd0, tk[0]});
    chk("taken1", {31'd0, taken1}, {31'd0, tk[1]});
    chk("npc0", npc0, m_npc(0));
    chk("npc1", npc1, m_npc(1));
    chk("idx0", {26'd0, idx0}, m_idx(0));
    chk("idx1", {26'd0, idx1}, m_idx(1));
    chk("ghr0", {26'd0, ghr0}, ghr_m[0]);
    chk("ghr1", {26'd0, ghr1}, ghr_m[1]);
    chk("perf_branch", pb0, pb_m);
    chk("perf_miss", pm1, pm_m);
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (e_tv && e_tm)        ghr_m[m] = (e_tghr * 2 + e_tt) % 64;
      else if (f_valid && f_br) ghr_m[m] = (ghr_m[m] * 2 + tk[m]) % 64;
    end
    if (e_tv) begin
      if (e_tt) cnt_m[e_tidx] = (cnt_m[e_tidx] == 3) ? 3 : cnt_m[e_tidx] + 1;
      else      cnt_m[e_tidx] = (cnt_m[e_tidx] == 0) ? 0 : cnt_m[e_tidx] - 1;
      pb_m++;
      if (e_tm) pm_m++;
    end
    #1;
  endtask

  task automatic train(input int idx, input bit tk, input int n);
    idle();
    e_tv = 1; e_tidx = idx[5:0]; e_tt = tk;
    repeat (n) cycle();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();
    idle();
    rst_n = 0;
    f_pc = 32'h100; f_br = 1; f_bt = 32'h140;
    #3;
    chk("rst_perf_branch", pb1, 32'd0);
    chk("rst_perf_miss", pm0, 32'd0);
    chk("rst_ghr1", {26'd0, ghr1}, 32'd0);
    chk("rst_taken", {31'd0, taken0}, 32'd0);
    chk("rst_npc", npc0, 32'h104);
    chk("rst_idx", {26'd0, idx0}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    cycle();

    // counter climbs to strongly taken, then saturates at 00
    train(0, 1, 2);
    idle(); f_pc = 32'h100; f_br = 1; f_bt = 32'h140; #1;
    chk("trained_npc", npc0, 32'h140);
    cycle();
    train(0, 0, 4);
    idle(); f_pc = 32'h100; f_br = 1; f_bt = 32'h140; #1;
    chk("sat_low_npc", npc0, 32'h104);
    cycle();

    // jal with counter at 00: taken, no history shift
    idle(); f_pc = 32'h100; f_valid = 1; f_jal = 1; f_jt = 32'h2000; #1;
    chk("jal_npc", npc0, 32'h2000);
    chk("jal_taken", {31'd0, taken0}, 32'd1);
    cycle();
    chk("jal_ghr", {26'd0, ghr1}, 32'd0);

    // gshare: indices 0, 1, 3 made taken so three fetches at 0x100 walk the history
    train(0, 1, 2);
    train(1, 1, 1);
    train(3, 1, 1);
    idle(); f_pc = 32'h100; f_valid = 1; f_br = 1; f_bt = 32'h140;
    repeat (3) cycle();
    chk("ghr_three_taken", {26'd0, ghr1}, 32'h07);
    // mispredict repair wins over same-cycle speculative shift
    e_tv = 1; e_tm = 1; e_tidx = 10; e_tt = 0; e_tghr = 6'b000011;
    cycle();
    chk("ghr_repair", {26'd0, ghr1}, 32'h06);
    chk("ghr_repair_bimodal", {26'd0, ghr0}, 32'h06);
    chk("miss_count", pm1, 32'd1);

    // same-cycle train and fetch of idx 5: no bypass
    idle(); f_pc = 32'h14; f_br = 1; f_bt = 32'h80;
    e_tv = 1; e_tidx = 5; e_tt = 1; #1;
    chk("no_bypass_taken", {31'd0, taken0}, 32'd0);
    chk("no_bypass_npc", npc0, 32'h18);
    cycle();
    e_tv = 0; #1;
    chk("after_train_taken", {31'd0, taken0}, 32'd1);
    chk("after_train_npc", npc0, 32'h80);
    cycle();

    // PC+4 wraps to zero
    idle(); f_pc = 32'hFFFF_FFFC; #1;
    chk("pc_wrap_npc", npc0, 32'h0);
    cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      f_pc    = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_03FC);
      f_bt    = $urandom;
      f_jt    = $urandom;
      f_valid = $urandom_range(0, 1);
      f_br    = ($urandom_range(0, 3) != 0);
      f_jal   = ($urandom_range(0, 5) == 0);
      e_tv    = $urandom_range(0, 1);
      e_tidx  = $urandom_range(0, 63);
      e_tt    = $urandom_range(0, 1);
      e_tm    = ($urandom_range(0, 3) == 0);
      e_tghr  = $urandom_range(0, 63);
      cycle();
    end

    // asynchronous reset between edges
    train(5, 1, 2);
    idle(); f_pc = 32'h14; f_br = 1; f_bt = 32'h80;
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("async_perf_branch", pb0, 32'd0);
    chk("async_perf_miss", pm1, 32'd0);
    chk("async_ghr1", {26'd0, ghr1}, 32'd0);
    chk("async_idx5_taken", {31'd0, taken0}, 32'd0);
    for (int i = 0; i < 64; i++) begin
      f_pc = i * 4;
      #1;
      chk("async_cnt_taken0", {31'd0, taken0}, 32'd0);
      chk("async_cnt_taken1", {31'd0, taken1}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1;
    idle();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
